mul_div_unit: RTL and testbench

Iterative 32-bit multiply/divide unit owning the architectural HI and LO registers. It sits directly downstream of the register file: it consumes the rs/rt read-port values, runs MULT/MULTU/DIV/DIVU over multiple cycles, and holds the 64-bit result in HI/LO. The MFHI/MFLO datapath reads HI/LO, and the pipeline stalls on `busy`.

---
 rtl/mdu_pkg.sv | 29 ++
 rtl/cond_neg.sv | 12 +
 rtl/mul_div_unit.sv | 196 +++++++++++++++++++
 tb/tb_mul_div_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;
  // One ITER step per operand bit.
  localparam int MDU_ITERS = MDU_WIDTH;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ITER = 2'b01,
    ST_FIX  = 2'b10
  } mdu_state_e;

  function automatic logic op_is_signed(input mdu_op_e o);
    return (o == MDU_MULT) || (o == MDU_DIV);
  endfunction

  function automatic logic op_is_div(input mdu_op_e o);
    return (o == MDU_DIV) || (o == MDU_DIVU);
  endfunction

endpackage

// File: rtl/cond_neg.sv
// Conditional two's-complement negate; passes the value through when neg_i is low.
module cond_neg #(
  parameter int W = 32
) (
  input  logic         neg_i,
  input  logic [W-1:0] a_i,
  output logic [W-1:0] y_o
);

  assign y_o = neg_i ? (~a_i + W'(1)) : a_i;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit holding the HI/LO registers.
// Multiply is a right-shifting shift-add; divide is restoring division.
// Both run on magnitudes and apply sign fixups in the FIX cycle.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(MDU_ITERS);

  mdu_state_e         state_q, state_d;
  mdu_op_e            op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;          // multiplicand, or dividend/quotient shifter
  logic [WIDTH-1:0]   b_q, b_d;          // multiplier shifter, or divisor
  logic [WIDTH-1:0]   raw_a_q, raw_a_d;  // unmodified A for the divide-by-zero result
  logic               neg_q_q, neg_q_d;
  logic               neg_r_q, neg_r_d;
  logic               div0_q, div0_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;      // product, or remainder in the low WIDTH+1 bits
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  mdu_op_e            op_in;
  logic               in_signed;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               cur_signed;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign op_in      = mdu_op_e'(op);
  assign in_signed  = op_is_signed(op_in);
  assign cur_signed = op_is_signed(op_q);

  cond_neg #(.W(WIDTH)) u_mag_a (
    .neg_i (in_signed & rs_val[WIDTH-1]),
    .a_i   (rs_val),
    .y_o   (a_mag)
  );

  cond_neg #(.W(WIDTH)) u_mag_b (
    .neg_i (in_signed & rt_val[WIDTH-1]),
    .a_i   (rt_val),
    .y_o   (b_mag)
  );

  cond_neg #(.W(2*WIDTH)) u_fix_prod (
    .neg_i (cur_signed & neg_q_q),
    .a_i   (acc_q),
    .y_o   (prod_fix)
  );

  cond_neg #(.W(WIDTH)) u_fix_quo (
    .neg_i (cur_signed & neg_q_q),
    .a_i   (a_q),
    .y_o   (quo_fix)
  );

  cond_neg #(.W(WIDTH)) u_fix_rem (
    .neg_i (cur_signed & neg_r_q),
    .a_i   (acc_q[WIDTH-1:0]),
    .y_o   (rem_fix)
  );

  // Shift-add step: add the multiplicand into the upper half, then shift right.
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (b_q[0] ? {1'b0, a_q} : '0);
  // Restoring step: bring in the next dividend bit and trial-subtract the divisor.
  assign div_shift = {acc_q[WIDTH-1:0], a_q[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, b_q};

  // Next-state and datapath update for the IDLE/ITER/FIX sequence.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    raw_a_d = raw_a_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    div0_d  = div0_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ITER;
          op_d    = op_in;
          a_d     = a_mag;
          b_d     = b_mag;
          raw_a_d = rs_val;
          neg_q_d = rs_val[WIDTH-1] ^ rt_val[WIDTH-1];
          neg_r_d = rs_val[WIDTH-1];
          div0_d  = (rt_val == '0);
          cnt_d   = '0;
          acc_d   = '0;
        end else begin
          if (mthi) hi_d = rs_val;
          if (mtlo) lo_d = rs_val;
        end
      end
      ST_ITER: begin
        cnt_d = cnt_q + CW'(1);
        if (op_is_div(op_q)) begin
          if (!div_trial[WIDTH]) begin
            acc_d = {{(WIDTH-1){1'b0}}, div_trial};
            a_d   = {a_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = {{(WIDTH-1){1'b0}}, div_shift};
            a_d   = {a_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          b_d   = b_q >> 1;
        end
        if (cnt_q == CW'(MDU_ITERS - 1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        if (op_is_div(op_q)) begin
          // Divide by zero overrides any sign fixup.
          if (div0_q) begin
            lo_d = '1;
            hi_d = raw_a_q;
          end else begin
            lo_d = quo_fix;
            hi_d = rem_fix;
          end
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything, even mid-operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      op_q    <= MDU_MULT;
      a_q     <= '0;
      b_q     <= '0;
      raw_a_q <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      div0_q  <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      raw_a_q <= raw_a_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      div0_q  <= div0_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed plus randomized bench for mul_div_unit against an arithmetic reference model.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .mthi   (mthi),
    .mtlo   (mtlo),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference result {hi,lo} from plain arithmetic on the architectural rules.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    longint      p;
    int          sa, sb;
    sa = int'(a);
    sb = int'(b);
    case (o)
      2'b00: begin
        p = longint'(sa) * longint'(sb);
        r = p;
      end
      2'b01: r = {32'h0, a} * {32'h0, b};
      2'b10: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
        else r = {32'(sa % sb), 32'(sa / sb)};
      end
      default: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else r = {a % b, a / b};
      end
    endcase
    return r;
  endfunction

  // Issue one op from the current time; returns just after the done edge.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input string tag, input int disturb_at, input bit with_mtlo);
    logic [63:0] e;
    int          n;
    bit          busy_gap;
    bit          hold_bad;
    e = model(o, a, b);
    op = o; rs_val = a; rt_val = b; start = 1'b1; mtlo = with_mtlo;
    @(posedge clk); #1;
    start = 1'b0; mtlo = 1'b0;
    rs_val = $urandom; rt_val = $urandom; op = 2'($urandom);
    chk({tag, " busy_at_E0"}, 64'(busy), 64'd1);
    chk({tag, " done_at_E0"}, 64'(done), 64'd0);
    chk({tag, " hold_at_E0"}, {hi, lo}, {exp_hi, exp_lo});
    n = 0; busy_gap = 1'b0; hold_bad = 1'b0;
    while (!done && n < 100) begin
      if (n == disturb_at) begin
        start = 1'b1; mthi = 1'b1; op = 2'b11; rs_val = 32'hDEAD; rt_val = 32'h3;
      end
      @(posedge clk); #1;
      n++;
      start = 1'b0; mthi = 1'b0;
      if (!done && !busy) busy_gap = 1'b1;
      if (!done && ({hi, lo} !== {exp_hi, exp_lo})) hold_bad = 1'b1;
    end
    chk({tag, " latency"}, 64'(n), 64'd33);
    chk({tag, " busy_gap"}, 64'(busy_gap), 64'd0);
    chk({tag, " hold_during_iter"}, 64'(hold_bad), 64'd0);
    chk({tag, " busy_after_fix"}, 64'(busy), 64'd0);
    chk({tag, " result"}, {hi, lo}, e);
    $display("op=%0d a=%08h b=%08h -> hi=%08h lo=%08h (%s)", o, a, b, hi, lo, tag);
    exp_hi = e[63:32];
    exp_lo = e[31:0];
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    // Reset values
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);

    // MULTU full scale, known constants as well as model
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_full", -1, 1'b0);
    chk("multu_full const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    @(posedge clk); #1;
    chk("done_one_cycle", 64'(done), 64'd0);

    @(negedge clk);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, "mult_signed", -1, 1'b0);
    chk("mult_signed const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);

    // DIV then DIVU back-to-back (start accepted on the first edge after FIX)
    @(negedge clk);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, "div_neg", -1, 1'b0);
    chk("div_neg const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(2'b11, 32'd100, 32'd7, "divu_b2b", -1, 1'b0);
    chk("divu_b2b const", {hi, lo}, {32'd2, 32'd14});

    // Edge cases
    @(negedge clk);
    run_op(2'b11, 32'h1234, 32'h0, "divu_by0", -1, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'h0, "div_by0", -1, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", -1, 1'b0);
    chk("div_ovf const", {hi, lo}, {32'h0, 32'h8000_0000});

    // start/mthi pulsed mid-ITER are ignored
    @(negedge clk);
    run_op(2'b01, 32'h0001_0001, 32'h3, "ignore_mid", 10, 1'b0);

    // MTHI in idle
    @(negedge clk);
    mthi = 1'b1; rs_val = 32'hCAFE;
    @(posedge clk); #1;
    mthi = 1'b0;
    chk("mthi hi", 64'(hi), 64'h0000_CAFE);
    chk("mthi lo_unchanged", 64'(lo), 64'(exp_lo));
    exp_hi = 32'hCAFE;

    // start wins over mtlo in the same cycle
    @(negedge clk);
    run_op(2'b10, 32'd50, 32'hFFFF_FFFB, "start_mtlo", -1, 1'b1);

    // MTHI and MTLO together
    @(negedge clk);
    mthi = 1'b1; mtlo = 1'b1; rs_val = 32'h5A5A_1234;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    chk("mthi_mtlo both", {hi, lo}, 64'h5A5A_1234_5A5A_1234);
    exp_hi = 32'h5A5A_1234; exp_lo = 32'h5A5A_1234;

    // Asynchronous reset mid-ITER
    @(negedge clk);
    op = 2'b01; rs_val = 32'd7; rt_val = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("async_reset busy", 64'(busy), 64'd0);
    chk("async_reset done", 64'(done), 64'd0);
    chk("async_reset hi", 64'(hi), 64'd0);
    chk("async_reset lo", 64'(lo), 64'd0);
    exp_hi = '0; exp_lo = '0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    run_op(2'b01, 32'd3, 32'd5, "after_reset", -1, 1'b0);

    // Randomized ops, some back-to-back, some with zero or small divisors
    for (int i = 0; i < 12; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 5) == 0) rb = 32'h0;
      else if (ro[1] && $urandom_range(0, 1) == 1) rb = 32'($urandom_range(1, 20));
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      run_op(ro, ra, rb, "random", -1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
